// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - RISC-V funct3 load/store size encodings
//   - FSM state type
//   - Held request record captured on a cache miss
//   - Misalignment helper
package mem_stage_lsu_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsu_state_t;

    // Everything needed to replay a request and align its load data
    // while the cache is still working on a miss.
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
    } lsu_req_t;

    // Halfwords need bit 0 clear, words need both low bits clear.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3)
            LS_H, LS_HU: mis = addr_lo[0];
            LS_W:        mis = |addr_lo;
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-cache request/ready bus between the LSU (master) and the cache (slave).
//   d_req/d_write/d_addr/d_wstrb/d_wdata : request, driven by the LSU
//   d_ready/d_rdata                      : completion and read word, driven by the cache
interface mem_stage_lsu_if;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [3:0]  d_wstrb;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;

    modport master (
        output d_req, d_write, d_addr, d_wstrb, d_wdata,
        input  d_ready, d_rdata
    );

    modport slave (
        input  d_req, d_write, d_addr, d_wstrb, d_wdata,
        output d_ready, d_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_ld_align.sv
// ld_align: combinational load-data alignment.
//   rdata   in  32  word returned by memory
//   addr_lo in  2   byte offset within the word
//   funct3  in  3   load size/sign encoding
//   data    out 32  selected byte/half/word, sign- or zero-extended
module ld_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LS_B:    data = {{24{byte_sel[7]}}, byte_sel};
            LS_BU:   data = {24'h0, byte_sel};
            LS_H:    data = {{16{half_sel[15]}}, half_sel};
            LS_HU:   data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit.
//   clk, rst (async, active-low)
//   m_valid/m_load/m_store/m_funct3/m_addr/m_wdata : operation from EX/MEM
//   flush        : kills the operation, honoured only while IDLE
//   dbus         : data-cache request/ready bus (master side)
//   next_ld_data : extended load result, non-zero only on a completing load
//   stop         : pipeline freeze while a miss is outstanding
//   misalign     : one-cycle flag for a misaligned access (no request issued)
//   stall_cnt    : saturating count of cycles with stop=1
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m_valid,
    input  logic                   m_load,
    input  logic                   m_store,
    input  logic [2:0]             m_funct3,
    input  logic [31:0]            m_addr,
    input  logic [31:0]            m_wdata,
    input  logic                   flush,
    mem_stage_lsu_if.master        dbus,
    output logic [31:0]            next_ld_data,
    output logic                   stop,
    output logic                   misalign,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    lsu_state_t state_reg, state_next;
    lsu_req_t   hold_reg, req_new, req_cur;

    logic       mis, is_mem, mem_op, req_out;
    logic [3:0] strb_mask;
    logic [31:0] aligned;

    assign mis    = is_misaligned(m_funct3, m_addr[1:0]);
    assign is_mem = m_valid & (m_load | m_store) & ~flush;
    assign mem_op = is_mem & ~mis;

    // Lane mask from size; funct3[1:0] carries the size for stores.
    always_comb begin
        case (m_funct3[1:0])
            2'b00:   strb_mask = 4'b0001 << m_addr[1:0];
            2'b01:   strb_mask = 4'b0011 << m_addr[1:0];
            default: strb_mask = 4'b1111;
        endcase
    end

    // Store data replicated so every enabled lane sees its own byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                case (m_funct3[1:0])
                    2'b00:   req_new.wdata[8*gi +: 8] = m_wdata[7:0];
                    2'b01:   req_new.wdata[8*gi +: 8] = m_wdata[8*(gi%2) +: 8];
                    default: req_new.wdata[8*gi +: 8] = m_wdata[8*gi +: 8];
                endcase
            end
        end
    endgenerate

    assign req_new.write   = m_store;
    assign req_new.addr    = {m_addr[31:2], 2'b00};
    assign req_new.wstrb   = m_store ? strb_mask : 4'b0000;
    assign req_new.funct3  = m_funct3;
    assign req_new.addr_lo = m_addr[1:0];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic; flush has no say once a miss is in flight.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (mem_op && !dbus.d_ready) state_next = ST_WAIT;
            ST_WAIT: if (dbus.d_ready)            state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_out  = 1'b0;
        stop     = 1'b0;
        misalign = 1'b0;
        req_cur  = req_new;
        case (state_reg)
            ST_IDLE: begin
                req_out  = mem_op;
                stop     = mem_op & ~dbus.d_ready;
                misalign = is_mem & mis;
            end
            ST_WAIT: begin
                req_out = 1'b1;
                stop    = ~dbus.d_ready;
                req_cur = hold_reg;
            end
            default: ;
        endcase
    end

    // Request snapshot taken in the first cycle of a miss keeps the bus
    // stable even if EX/MEM contents move on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            hold_reg <= '0;
        else if (state_reg == ST_IDLE && mem_op && !dbus.d_ready)
            hold_reg <= req_new;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (stop && !(&stall_cnt))
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end

    assign dbus.d_req   = req_out;
    assign dbus.d_write = req_cur.write;
    assign dbus.d_addr  = req_cur.addr;
    assign dbus.d_wstrb = req_cur.wstrb;
    assign dbus.d_wdata = req_cur.wdata;

    ld_align u_ld_align (
        .rdata   (dbus.d_rdata),
        .addr_lo (req_cur.addr_lo),
        .funct3  (req_cur.funct3),
        .data    (aligned)
    );

    assign next_ld_data = (req_out && dbus.d_ready && !req_cur.write) ? aligned : 32'h0;

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage of the pipelined CPU with cache. It takes the memory operation latched in the EX/MEM register and drives the data-cache request/ready handshake. It holds `stop` high while a cache miss is outstanding. It aligns and sign/zero-extends load data and hands it to the MEM/WB register as `next_ld_data`.

## Interface
Parameters:
- `STALL_CNT_W`, 32: width of the saturating stall-cycle counter.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `m_valid`  in  1  EX/MEM holds a valid instruction.
- `m_load`  in  1  instruction is a load.
- `m_store`  in  1  instruction is a store.
- `m_funct3`  in  3  RISC-V size/sign field: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `m_addr`  in  32  effective address (ALU result).
- `m_wdata`  in  32  store source register value.
- `flush`  in  1  kill current MEM instruction; has effect only in IDLE.
- `d_req`  out  1  cache request.
- `d_write`  out  1  request is a store.
- `d_addr`  out  32  word-aligned address, with `[1:0]`=0.
- `d_wstrb`  out  4  byte enables for stores; 0 for loads.
- `d_wdata`  out  32  store data replicated to byte lanes.
- `d_ready`  in  1  cache completes the request this cycle; equivalent to PReady.
- `d_rdata`  in  32  cache read word, valid when `d_ready`=1.
- `next_ld_data`  out  32  extended load result.
- `stop`  out  1  freeze the pipeline.
- `misalign`  out  1  one-cycle misaligned-access flag.
- `stall_cnt`  out  `STALL_CNT_W`  cycles spent with `stop`=1, saturating.

## Operation
- `mem_op = m_valid & (m_load|m_store) & ~flush & ~mis`.
- `mis` is set for H/HU with `addr[0]`=1, and for W with `addr[1:0]`≠0.
- FSM states: IDLE and WAIT.
- IDLE:
  - `d_req = mem_op`, with `d_addr`, `d_wstrb` and `d_wdata` derived combinationally.
  - If `mem_op & d_ready`, this is a hit: stay in IDLE with `stop`=0.
  - If `mem_op & ~d_ready`, latch `d_addr`, `d_write`, `d_wstrb`, `d_wdata`, `funct3` and `addr[1:0]` into holding registers, then go to WAIT. `stop`=1 in that same cycle.
- WAIT:
  - `d_req`=1, and all request fields come from the holding registers.
  - `flush` is ignored in WAIT; the cache transaction always completes.
  - While `~d_ready`, `stop`=1.
  - On `d_ready`, `stop`=0, return to IDLE, and the pipeline advances in that cycle.
- Stores:
  - B: `wstrb = 0001<<addr[1:0]`, `wdata = {4{b}}`.
  - H: `wstrb = 0011<<addr[1:0]`, `wdata = {2{h}}`.
  - W: `wstrb = 1111`.
- Loads:
  - Select the byte/half by `addr[1:0]` from `d_rdata`.
  - B/H sign-extend; BU/HU zero-extend.
  - `next_ld_data` is valid only when `d_ready`=1; otherwise it is 0.
- Misaligned access: no request is issued, `misalign`=1 for that cycle, and `next_ld_data`=0.
- `stall_cnt` increments every cycle `stop`=1 and saturates at all-ones.

## Timing
- Reset values: state IDLE, holding registers 0, `stall_cnt` 0.
- Consequently, during reset `d_req`/`stop`/`misalign` are 0 whenever `m_valid`=0.
- Hit: zero added latency; `stop` is never asserted.
- Miss with N cycles until `d_ready`: `stop` is high for exactly N cycles, and `stall_cnt` grows by N.
- `d_req` and the request fields stay stable from the first cycle of a miss until `d_ready`.
- Reset asserted mid-WAIT: immediately return to IDLE and drop `d_req`. The cache is reset by the same `rst`.
- Back-to-back memory operations: the next op may issue in the cycle after `d_ready`. No idle bubble is required.

## Structure
- Shared package: funct3 size encodings (`LS_B`, `LS_H`, `LS_W`, `LS_BU`, `LS_HU`) and the FSM state constants.
- One natural sub-module, `ld_align`: combinational byte/half select plus extension, from (`rdata`, `addr[1:0]`, `funct3`). It is reused by any future uncached path.

## Test plan
- Load-byte hit:
  - `addr`=0x1003, LB, `d_ready`=1 in the same cycle, `d_rdata`=0x80AA_BBCC.
  - Expect `next_ld_data`=0xFFFF_FF80 and `stop` never high.
- Store-half miss:
  - SH to 0x2002 with `m_wdata`=0x1234_ABCD, `d_ready` after 3 cycles.
  - Expect `d_wstrb`=1100, `d_wdata`=0xABCD_ABCD, and `d_addr`=0x2000 held stable.
  - Expect `stop` high for 3 cycles and `stall_cnt`=3.
- Misaligned LW:
  - LW at 0x3001.
  - Expect `d_req`=0, one-cycle `misalign`, `next_ld_data`=0, and `stop`=0.
- Flush:
  - `flush`=1 in IDLE with a valid load: expect no `d_req`.
  - `flush`=1 during WAIT: expect `d_req` held until `d_ready`.
- Reset mid-miss:
  - Drop `rst` during WAIT.
  - Expect `d_req`=0 and state IDLE immediately; expect `stall_cnt`=0 after release.
- Back-to-back operations and saturation:
  - A miss LHU at 0x4002 returning 0xFEDC_0000, immediately followed by a hit SW.
  - Expect `next_ld_data`=0x0000_FEDC, then `d_wstrb`=1111 in the next cycle.
  - With `STALL_CNT_W`=4 and a 20-cycle miss, expect `stall_cnt`=15.
